// File: rtl/seat_table_ctrl.sv
// seat_table_ctrl: seat-occupancy table with request FSM, manager config and background expiry sweep.
// Define SEAT_AWAY_LIMIT_EN to add a separate expiry limit for AWAY seats (written via cfg_sel=3).
module seat_table_ctrl #(
    parameter int N_SEATS       = 32,
    parameter int SID_W         = 32,
    parameter int TIME_W        = 11,
    parameter int DEFAULT_LIMIT = 120,
    localparam int SW           = $clog2(N_SEATS)
) (
    input  logic              clk_mem,
    input  logic              rst_mem,
    input  logic [TIME_W-1:0] time_now,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SID_W-1:0]  req_sid,
    input  logic [SW-1:0]     req_seat,
    input  logic [1:0]        req_state,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [1:0]        cfg_ban,
    input  logic [TIME_W-1:0] cfg_limit,
    output logic              resp_valid,
    output logic [2:0]        resp_code,
    output logic              expire_valid,
    output logic [SW-1:0]     expire_seat,
    output logic [SW:0]       occ_count
);
    typedef enum logic {IDLE, EXEC} fsm_t;
    localparam logic [1:0] FREE = 2'd0, IN_USE = 2'd1, AWAY = 2'd2, BANNED = 2'd3;
    fsm_t              fsm_q;
    logic [SID_W-1:0]  owner_q [N_SEATS];
    logic [TIME_W-1:0] ts_q [N_SEATS];
    logic [1:0]        st_q [N_SEATS];
    logic [TIME_W-1:0] limit_q;
    logic [SW-1:0]     ptr_q;
    logic              resp_valid_q;
    logic [2:0]        resp_code_q;
    logic              expire_valid_q;
    logic [SW-1:0]     expire_seat_q;
    logic [SW:0]       occ_q;
    logic [SW:0]       occ_d;
    logic              accept;
    logic              sweep;
    logic              other_own;
    logic              expire_d;
    logic [1:0]        cur_st;
    logic [SID_W-1:0]  cur_owner;
    logic [2:0]        code_d;
    logic [TIME_W-1:0] elapsed;
`ifdef SEAT_AWAY_LIMIT_EN
    logic [TIME_W-1:0] away_limit_q;
`endif
    assign req_ready    = fsm_q == IDLE && !cfg_we;
    assign accept       = req_valid && req_ready;
    assign sweep        = fsm_q == IDLE && !req_valid && !cfg_we;
    assign resp_valid   = resp_valid_q;
    assign resp_code    = resp_code_q;
    assign expire_valid = expire_valid_q;
    assign expire_seat  = expire_seat_q;
    assign occ_count    = occ_q;
    assign cur_st       = st_q[req_seat];
    assign cur_owner    = owner_q[req_seat];
    assign elapsed      = time_now - ts_q[ptr_q];
    always_comb begin
        other_own = 1'b0;
        occ_d     = '0;
        for (int i = 0; i < N_SEATS; i++) begin
            if (SW'(i) != req_seat && owner_q[i] == req_sid) other_own = 1'b1;
            occ_d = occ_d + (SW+1)'(st_q[i] == IN_USE || st_q[i] == AWAY);
        end
        code_d = {1'b0, req_seat} >= (SW+1)'(N_SEATS) ? 3'd6 :
                 req_sid == '0 || req_state == BANNED || (cur_st == FREE && req_state == AWAY) ? 3'd7 :
                 cur_st == BANNED ? 3'd3 :
                 req_state == cur_st ? 3'd2 :
                 cur_owner != '0 && cur_owner != req_sid ? 3'd5 :
                 other_own ? 3'd4 :
                 req_state == FREE ? 3'd1 : 3'd0;
        expire_d = st_q[ptr_q] == IN_USE && elapsed >= limit_q;
`ifdef SEAT_AWAY_LIMIT_EN
        expire_d = expire_d || (st_q[ptr_q] == AWAY && elapsed >= away_limit_q);
`endif
        expire_d = expire_d && sweep;
    end
    // The table is stable between accept and EXEC, so the result is decided and committed at accept.
    always_ff @(posedge clk_mem or posedge rst_mem) begin
        if (rst_mem) begin
            fsm_q          <= IDLE;
            limit_q        <= TIME_W'(DEFAULT_LIMIT);
            ptr_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_code_q    <= '0;
            expire_valid_q <= 1'b0;
            expire_seat_q  <= '0;
            occ_q          <= '0;
`ifdef SEAT_AWAY_LIMIT_EN
            away_limit_q   <= TIME_W'(DEFAULT_LIMIT);
`endif
            for (int i = 0; i < N_SEATS; i++) begin
                owner_q[i] <= '0;
                ts_q[i]    <= '0;
                st_q[i]    <= FREE;
            end
        end else begin
            occ_q          <= occ_d;
            resp_valid_q   <= 1'b0;
            expire_valid_q <= expire_d;
            if (expire_d) begin
                expire_seat_q  <= ptr_q;
                st_q[ptr_q]    <= FREE;
                owner_q[ptr_q] <= '0;
                ts_q[ptr_q]    <= '0;
            end
            if (sweep) ptr_q <= ptr_q == SW'(N_SEATS-1) ? '0 : ptr_q + 1'b1;
            if (fsm_q == EXEC) begin
                fsm_q <= IDLE;
            end else if (accept) begin
                fsm_q        <= EXEC;
                resp_valid_q <= 1'b1;
                resp_code_q  <= code_d;
                if (code_d <= 3'd1) begin
                    owner_q[req_seat] <= code_d == 3'd0 ? req_sid : '0;
                    ts_q[req_seat]    <= code_d == 3'd0 ? time_now : '0;
                    st_q[req_seat]    <= req_state;
                end
            end else if (cfg_we) begin
                if (cfg_sel == 2'd2) limit_q <= cfg_limit;
`ifdef SEAT_AWAY_LIMIT_EN
                if (cfg_sel == 2'd3) away_limit_q <= cfg_limit;
`endif
                if (cfg_sel == 2'd1 && cfg_ban != 2'd3) begin
                    for (int i = 0; i < N_SEATS; i++) begin
                        if (!cfg_ban[1] && i[0] == cfg_ban[0]) begin
                            st_q[i]    <= BANNED;
                            owner_q[i] <= '0;
                            ts_q[i]    <= '0;
                        end else if (st_q[i] == BANNED) begin
                            st_q[i] <= FREE;
                        end
                    end
                end
            end
        end
    end
endmodule
